// File: rtl/flick_conditioner_if.sv
// Flick button bundle: raw push-button level in, conditioned flick outputs back.
interface flick_conditioner_if;
  logic       flick_raw;
  logic       flick_out;
  logic       flick_db;
  logic       flick_pulse;
  logic [7:0] press_count;

  // Drives the button, observes the conditioned outputs.
  modport master (
    output flick_raw,
    input  flick_out,
    input  flick_db,
    input  flick_pulse,
    input  press_count
  );

  // The conditioner itself.
  modport slave (
    input  flick_raw,
    output flick_out,
    output flick_db,
    output flick_pulse,
    output press_count
  );
endinterface

// File: rtl/flick_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, 4-state debounce FSM,
// minimum-width stretcher for the flasher flick input, and a press counter.
module flick_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STRETCH_CYCLES  = 8
) (
  input logic                clk,
  input logic                rst,
  flick_conditioner_if.slave bus
);

  localparam logic [15:0] DB_LAST      = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  STRETCH_LOAD = 8'(STRETCH_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW,
    RISE_CHK,
    HIGH,
    FALL_CHK
  } state_t;

  state_t      state;
  logic        s1;
  logic        s2;
  logic [15:0] db_cnt;
  logic [7:0]  stretch_cnt;
  logic        db_q;
  logic        out_q;
  logic        pulse_q;
  logic [7:0]  count_q;
  logic        rise_ok;
  logic        fall_ok;

  // Debounce window completion for the current state.
  always_comb begin
    rise_ok = 1'b0;
    fall_ok = 1'b0;
    if (state == RISE_CHK && s2 && db_cnt == DB_LAST) rise_ok = 1'b1;
    if (state == FALL_CHK && !s2 && db_cnt == DB_LAST) fall_ok = 1'b1;
  end

  // Synchronizer, debounce FSM, stretcher and counter, all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state       <= LOW;
      db_cnt      <= '0;
      stretch_cnt <= '0;
      db_q        <= 1'b0;
      out_q       <= 1'b0;
      pulse_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      s1      <= bus.flick_raw;
      s2      <= s1;
      pulse_q <= 1'b0;

      if (stretch_cnt != '0) stretch_cnt <= stretch_cnt - 8'd1;

      // flick_out tracks the next debounced level, held up while the stretcher
      // still has cycles left before this edge's decrement.
      out_q <= rise_ok | (db_q & ~fall_ok) | (stretch_cnt != '0);

      case (state)
        LOW: begin
          if (s2) begin
            state  <= RISE_CHK;
            db_cnt <= '0;
          end
        end
        RISE_CHK: begin
          if (!s2) begin
            state  <= LOW;
            db_cnt <= '0;
          end else if (rise_ok) begin
            state       <= HIGH;
            db_cnt      <= '0;
            db_q        <= 1'b1;
            pulse_q     <= 1'b1;
            count_q     <= count_q + 8'd1;
            stretch_cnt <= STRETCH_LOAD;
          end else begin
            db_cnt <= db_cnt + 16'd1;
          end
        end
        HIGH: begin
          if (!s2) begin
            state  <= FALL_CHK;
            db_cnt <= '0;
          end
        end
        FALL_CHK: begin
          if (s2) begin
            state  <= HIGH;
            db_cnt <= '0;
          end else if (fall_ok) begin
            state  <= LOW;
            db_cnt <= '0;
            db_q   <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 16'd1;
          end
        end
        default: begin
          state  <= LOW;
          db_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.flick_out   = out_q;
  assign bus.flick_db    = db_q;
  assign bus.flick_pulse = pulse_q;
  assign bus.press_count = count_q;

endmodule

// File: tb/tb_flick_conditioner.sv
// Scoreboard bench for flick_conditioner: directed presses push expected
// edge events; a negedge monitor pops and compares on every output change.
module tb_flick_conditioner;

  localparam int D  = 4;
  localparam int S  = 8;
  localparam int SB = 12;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  flick_conditioner_if bus_a ();
  flick_conditioner_if bus_b ();

  flick_conditioner #(.DEBOUNCE_CYCLES(D), .STRETCH_CYCLES(S)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  // Longer stretch so a re-press can be accepted while the stretcher runs.
  flick_conditioner #(.DEBOUNCE_CYCLES(D), .STRETCH_CYCLES(SB)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         dut;
    int         cyc;
    logic       val;
    logic [7:0] cnt;
  } ev_t;

  ev_t q_db[$];
  ev_t q_out[$];
  ev_t q_pulse[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;
  logic prev_db[2];
  logic prev_out[2];

  function automatic ev_t mk(input int d, input int c, input logic v, input logic [7:0] n);
    ev_t e;
    e.dut = d;
    e.cyc = c;
    e.val = v;
    e.cnt = n;
    return e;
  endfunction

  // Monitor: every change of flick_db/flick_out and every high flick_pulse
  // must match the next expected event of that kind.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        logic       db;
        logic       out;
        logic       pl;
        logic [7:0] cnt;
        ev_t        e;
        db  = (d == 0) ? bus_a.flick_db    : bus_b.flick_db;
        out = (d == 0) ? bus_a.flick_out   : bus_b.flick_out;
        pl  = (d == 0) ? bus_a.flick_pulse : bus_b.flick_pulse;
        cnt = (d == 0) ? bus_a.press_count : bus_b.press_count;

        if (db !== prev_db[d]) begin
          n_checks++;
          if (q_db.size() == 0) begin
            n_fail++;
            $display("FAIL db_edge: dut%0d flick_db -> %b at cycle %0d, required no change", d, db, cyc);
          end else begin
            e = q_db.pop_front();
            if (e.dut != d || e.cyc != cyc || e.val !== db) begin
              n_fail++;
              $display("FAIL db_edge: got dut%0d val %b cycle %0d, required dut%0d val %b cycle %0d",
                       d, db, cyc, e.dut, e.val, e.cyc);
            end
          end
          prev_db[d] = db;
        end

        if (out !== prev_out[d]) begin
          n_checks++;
          if (q_out.size() == 0) begin
            n_fail++;
            $display("FAIL out_edge: dut%0d flick_out -> %b at cycle %0d, required no change", d, out, cyc);
          end else begin
            e = q_out.pop_front();
            if (e.dut != d || e.cyc != cyc || e.val !== out) begin
              n_fail++;
              $display("FAIL out_edge: got dut%0d val %b cycle %0d, required dut%0d val %b cycle %0d",
                       d, out, cyc, e.dut, e.val, e.cyc);
            end
          end
          prev_out[d] = out;
        end

        if (pl !== 1'b0) begin
          n_checks++;
          if (q_pulse.size() == 0) begin
            n_fail++;
            $display("FAIL pulse: dut%0d flick_pulse=%b at cycle %0d, required no pulse", d, pl, cyc);
          end else begin
            e = q_pulse.pop_front();
            if (e.dut != d || e.cyc != cyc || pl !== 1'b1 || cnt !== e.cnt) begin
              n_fail++;
              $display("FAIL pulse: got dut%0d cycle %0d count %0d, required dut%0d cycle %0d count %0d",
                       d, cyc, cnt, e.dut, e.cyc, e.cnt);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_raw(input int d, input logic v);
    if (d == 0) bus_a.flick_raw = v;
    else        bus_b.flick_raw = v;
  endtask

  // Isolated clean press of hi samples (hi >= D+1): rise D+3 edges after the
  // first high sample, fall D+3 edges after the first low sample, flick_out
  // falls at the later of the flick_db fall and rise+stretch.
  task automatic press(input int d, input int hi, input int lo, input logic [7:0] n, input int s);
    int c;
    int rise;
    int fall;
    int ofall;
    c     = cyc;
    rise  = c + D + 3;
    fall  = c + hi + D + 3;
    ofall = (fall > rise + s) ? fall : rise + s;
    q_db.push_back(mk(d, rise, 1'b1, 8'd0));
    q_db.push_back(mk(d, fall, 1'b0, 8'd0));
    q_out.push_back(mk(d, rise, 1'b1, 8'd0));
    q_out.push_back(mk(d, ofall, 1'b0, 8'd0));
    q_pulse.push_back(mk(d, rise, 1'b1, n));
    set_raw(d, 1'b1);
    tick(hi);
    set_raw(d, 1'b0);
    tick(lo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.flick_raw = 1'b0;
    bus_b.flick_raw = 1'b0;
    tick(3);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset values
    check("rst_out",   int'(bus_a.flick_out),   0);
    check("rst_db",    int'(bus_a.flick_db),    0);
    check("rst_pulse", int'(bus_a.flick_pulse), 0);
    check("rst_count", int'(bus_a.press_count), 0);
    check("rst_b_out", int'(bus_b.flick_out),   0);
    prev_db[0]  = 1'b0;
    prev_db[1]  = 1'b0;
    prev_out[0] = 1'b0;
    prev_out[1] = 1'b0;
    mon_en = 1'b1;

    // Bounce: high 3, low 1, five times; nothing may be accepted
    for (int i = 0; i < 5; i++) begin
      set_raw(0, 1'b1);
      tick(3);
      set_raw(0, 1'b0);
      tick(1);
    end
    tick(12);
    check("bounce_count", int'(bus_a.press_count), 0);
    check("bounce_db",    int'(bus_a.flick_db),    0);

    // Clean press, 20 cycles high
    press(0, 20, 20, 8'd1, S);
    check("clean_count", int'(bus_a.press_count), 1);

    // Short press, 7 cycles high: flick_db 7 cycles, flick_out 8 cycles
    press(0, 7, 12, 8'd2, S);
    check("short_count", int'(bus_a.press_count), 2);

    // Reset mid-stretch with raw held high
    c = cyc;
    q_db.push_back(mk(0, c + 7, 1'b1, 8'd0));
    q_out.push_back(mk(0, c + 7, 1'b1, 8'd0));
    q_pulse.push_back(mk(0, c + 7, 1'b1, 8'd3));
    set_raw(0, 1'b1);
    tick(9);
    q_db.push_back(mk(0, c + 10, 1'b0, 8'd0));
    q_out.push_back(mk(0, c + 10, 1'b0, 8'd0));
    rst_a = 1'b1;
    tick(1);
    rst_a = 1'b0;
    check("midrst_count", int'(bus_a.press_count), 0);
    check("midrst_pulse", int'(bus_a.flick_pulse), 0);
    check("midrst_db",    int'(bus_a.flick_db),    0);
    check("midrst_out",   int'(bus_a.flick_out),   0);
    q_db.push_back(mk(0, c + 17, 1'b1, 8'd0));
    q_out.push_back(mk(0, c + 17, 1'b1, 8'd0));
    q_pulse.push_back(mk(0, c + 17, 1'b1, 8'd1));
    tick(10);
    q_db.push_back(mk(0, c + 27, 1'b0, 8'd0));
    q_out.push_back(mk(0, c + 27, 1'b0, 8'd0));
    set_raw(0, 1'b0);
    tick(12);
    check("midrst_recount", int'(bus_a.press_count), 1);

    // Wrap: clear the counter, then 256 presses
    rst_a = 1'b1;
    tick(1);
    rst_a = 1'b0;
    check("wrap_start", int'(bus_a.press_count), 0);
    for (int k = 1; k <= 256; k++) begin
      press(0, 10, 10, 8'(k), S);
      if (k == 255) check("wrap_255", int'(bus_a.press_count), 255);
      if (k == 256) check("wrap_256", int'(bus_a.press_count), 0);
    end

    // Re-press accepted during stretch (stretch 12): raw high samples 1..5,
    // low 6..10, high 11..20; flick_out must stay high from 7 through 29.
    c = cyc;
    q_db.push_back(mk(1, c + 7,  1'b1, 8'd0));
    q_db.push_back(mk(1, c + 12, 1'b0, 8'd0));
    q_db.push_back(mk(1, c + 17, 1'b1, 8'd0));
    q_db.push_back(mk(1, c + 27, 1'b0, 8'd0));
    q_out.push_back(mk(1, c + 7,  1'b1, 8'd0));
    q_out.push_back(mk(1, c + 29, 1'b0, 8'd0));
    q_pulse.push_back(mk(1, c + 7,  1'b1, 8'd1));
    q_pulse.push_back(mk(1, c + 17, 1'b1, 8'd2));
    set_raw(1, 1'b1);
    tick(5);
    set_raw(1, 1'b0);
    tick(5);
    set_raw(1, 1'b1);
    tick(10);
    set_raw(1, 1'b0);
    tick(20);
    check("repress_count", int'(bus_b.press_count), 2);

    tick(5);
    check("q_db_left",    q_db.size(),    0);
    check("q_out_left",   q_out.size(),   0);
    check("q_pulse_left", q_pulse.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flick_conditioner.md
FLICK_CONDITIONER -- requirements
Module: flick_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive synchronized-stable cycles required to accept a level change; legal range 1..65535.
REQ-002 Parameter STRETCH_CYCLES, default 8: minimum number of cycles flick_out stays high per accepted press; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flick_raw  input  1  asynchronous, bouncy push-button level (1 = pressed).
REQ-006 flick_out  output  1  conditioned flick level, drives the bound flasher flick input.
REQ-007 flick_db  output  1  debounced level, no stretching.
REQ-008 flick_pulse  output  1  one-cycle strobe per accepted press.
REQ-009 press_count  output  8  number of accepted presses, modulo 256.

Function
REQ-010 flick_raw SHALL pass through a 2-flop synchronizer (s1, s2); only s2 is used by the FSM.
REQ-011 FSM states SHALL be LOW, RISE_CHK, HIGH, FALL_CHK; the debounce counter is cleared on every state entry.
REQ-012 LOW: s2=1 -> RISE_CHK; else stay.
REQ-013 RISE_CHK: s2=0 -> LOW (glitch rejected, no output change); s2=1 with counter = DEBOUNCE_CYCLES-1 -> HIGH; else counter +1.
REQ-014 HIGH: s2=0 -> FALL_CHK; else stay.
REQ-015 FALL_CHK: s2=1 -> HIGH; s2=0 with counter = DEBOUNCE_CYCLES-1 -> LOW; else counter +1.
REQ-016 flick_db SHALL be registered and equal 1 exactly while the state is HIGH or FALL_CHK.
REQ-017 Latency: flick_db SHALL assert after exactly DEBOUNCE_CYCLES+3 rising edges, counting the first edge that samples flick_raw high; release latency SHALL be symmetric.
REQ-018 flick_pulse SHALL be high for exactly the one cycle after the RISE_CHK->HIGH transition; FALL_CHK->HIGH SHALL NOT pulse.
REQ-019 On RISE_CHK->HIGH, the stretch counter SHALL load STRETCH_CYCLES-1; it decrements by 1 per cycle while nonzero and saturates at 0.
REQ-020 flick_out SHALL be registered, rise in the same cycle as flick_db, and stay high while flick_db=1 or the stretch counter is nonzero; high time = max(debounced high time, STRETCH_CYCLES) cycles.
REQ-021 A new accepted press while the stretch counter is nonzero SHALL reload it; flick_out SHALL show no low gap.
REQ-022 press_count SHALL increment by 1 in the cycle flick_pulse is high and wrap 255 -> 0.
REQ-023 An input toggling faster than DEBOUNCE_CYCLES SHALL produce no flick_pulse and no change on flick_db.

Reset
REQ-024 rst=1 at a rising edge SHALL take priority over all other activity; s1, s2, debounce counter and stretch counter clear to 0; state goes to LOW.
REQ-025 Reset values: flick_out=0, flick_db=0, flick_pulse=0, press_count=0.
REQ-026 Reset asserted mid-debounce or mid-stretch SHALL abort it with no pulse or count; after release, flick_raw held high SHALL be treated as a new press with full latency.

Verification (DEBOUNCE_CYCLES=4, STRETCH_CYCLES=8)
REQ-027 Clean press: raw 0->1 held 20 cycles -> flick_db and flick_out rise 7 edges after the first high sample; flick_pulse is high for 1 cycle; press_count=1.
REQ-028 Bounce: raw high 3 cycles, low 1 cycle, repeated 5 times, then low -> flick_db=0, flick_pulse never asserts, press_count=0.
REQ-029 Short press: raw high for exactly 7 cycles -> flick_db high for 7 cycles; flick_out high for 8 cycles.
REQ-030 Wrap: 256 clean presses, each 10 cycles high and 10 cycles low -> press_count reads 255 after press 255 and 0 after press 256.
REQ-031 Reset mid-op: rst pulsed 1 cycle while the stretch counter is nonzero and raw=1 -> all outputs 0 on the next edge; flick_db re-rises 7 edges after rst is released.
REQ-032 Re-press during stretch: release, then re-press accepted while the stretch counter is nonzero -> flick_out stays continuously high; second flick_pulse is seen; press_count=2.
